dac_spi_driver: RTL and testbench

- Downstream stage of the ddfs block. Consumes each 12-bit sample on q and writes it to an external MCP4921-class 12-bit SPI DAC.
- Each accepted sample becomes one 16-bit frame: 4 config bits followed by 12 data bits, MSB first.
- The frame is followed by an LDAC pulse so the DAC output updates synchronously.
- A one-entry pending buffer absorbs a sample that arrives while a frame is in flight. Loss is flagged and never silent.

---
 rtl/dac_spi_driver.sv | 144 ++++++++++++++
 tb/tb_dac_spi_driver.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_spi_driver.sv
// Serialises 12-bit ddfs samples into 16-bit SPI frames for an MCP4921-class DAC,
// then pulses LDAC. A one-entry pending buffer absorbs a sample that arrives mid-frame.
module dac_spi_driver #(
    parameter int unsigned CLK_DIV  = 2,
    parameter logic [3:0]  CFG_BITS = 4'b0011
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] sample,
    input  logic        sample_valid,
    input  logic        clr_overrun,
    output logic        ready,
    output logic        busy,
    output logic        overrun,
    output logic        dac_cs_n,
    output logic        dac_sclk,
    output logic        dac_sdi,
    output logic        dac_ldac_n
);

    localparam int unsigned DW = 12;
    localparam int unsigned FW = 16;
    localparam int unsigned CW = 8;
    localparam int unsigned BW = 4;
    localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, CSHI, LDAC} state_t;

    state_t         state, state_d;
    logic [CW-1:0]  cnt, cnt_d;
    logic [BW-1:0]  bit_idx, bit_d;
    logic           phase, phase_d;
    logic [FW-1:0]  shreg, shreg_d;
    logic [DW-1:0]  pend, pend_d;
    logic           pend_full, pend_full_d;
    logic           overrun_d, ready_d, busy_d;
    logic           cs_n_d, sclk_d, sdi_d, ldac_n_d;
    logic           div_last, drain, start_new, drop;

    // State, datapath and pin registers; pins are driven from next-state values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            phase      <= 1'b0;
            shreg      <= '0;
            pend       <= '0;
            pend_full  <= 1'b0;
            overrun    <= 1'b0;
            ready      <= 1'b1;
            busy       <= 1'b0;
            dac_cs_n   <= 1'b1;
            dac_sclk   <= 1'b0;
            dac_sdi    <= 1'b0;
            dac_ldac_n <= 1'b1;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            bit_idx    <= bit_d;
            phase      <= phase_d;
            shreg      <= shreg_d;
            pend       <= pend_d;
            pend_full  <= pend_full_d;
            overrun    <= overrun_d;
            ready      <= ready_d;
            busy       <= busy_d;
            dac_cs_n   <= cs_n_d;
            dac_sclk   <= sclk_d;
            dac_sdi    <= sdi_d;
            dac_ldac_n <= ldac_n_d;
        end
    end

    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        bit_d       = bit_idx;
        phase_d     = phase;
        shreg_d     = shreg;
        pend_d      = pend;
        pend_full_d = pend_full;
        drop        = 1'b0;

        div_last  = (cnt == DIV_LAST);
        drain     = (state == IDLE) && pend_full;
        start_new = (state == IDLE) && !pend_full && sample_valid;

        case (state)
            IDLE: begin
                // A buffered sample always goes out before a fresh strobe.
                if (drain || start_new) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    bit_d   = BW'(FW - 1);
                    phase_d = 1'b0;
                    shreg_d = {CFG_BITS, (drain ? pend : sample)};
                end
            end
            SHIFT: begin
                cnt_d = div_last ? '0 : cnt + CW'(1);
                if (div_last) begin
                    phase_d = !phase;
                    if (phase) begin
                        if (bit_idx == '0) begin
                            state_d = CSHI;
                        end else begin
                            bit_d   = bit_idx - BW'(1);
                            shreg_d = {shreg[FW-2:0], 1'b0};
                        end
                    end
                end
            end
            CSHI, LDAC: begin
                cnt_d = div_last ? '0 : cnt + CW'(1);
                if (div_last) begin
                    state_d = (state == CSHI) ? LDAC : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Pending slot: a drain in this cycle frees room for a coincident strobe.
        if (sample_valid && !start_new) begin
            if (!pend_full || drain) begin
                pend_d      = sample;
                pend_full_d = 1'b1;
            end else begin
                drop = 1'b1;
            end
        end else if (drain) begin
            pend_full_d = 1'b0;
        end

        overrun_d = drop || (overrun && !clr_overrun);
        ready_d   = !pend_full_d;
        busy_d    = (state_d != IDLE);
        cs_n_d    = (state_d != SHIFT);
        sclk_d    = (state_d == SHIFT) && phase_d;
        sdi_d     = (state_d == SHIFT) && shreg_d[FW-1];
        ldac_n_d  = (state_d != LDAC);
    end

endmodule

// File: tb/tb_dac_spi_driver.sv
// Scoreboard bench for dac_spi_driver at CLK_DIV=2 and CLK_DIV=1: a frame-level
// timing model predicts frames, start cycles, busy/ready/overrun; a monitor decodes the SPI pins.
module tb_dac_spi_driver;

    localparam int unsigned NI = 2;

    typedef struct {
        int          inst;
        logic [15:0] frame;
        int          start;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n        [NI];
    logic [11:0] sample       [NI];
    logic        sample_valid [NI];
    logic        clr_overrun  [NI];
    logic        ready        [NI];
    logic        busy         [NI];
    logic        overrun      [NI];
    logic        cs_n         [NI];
    logic        sclk         [NI];
    logic        sdi          [NI];
    logic        ldac_n       [NI];

    dac_spi_driver #(.CLK_DIV(2)) u_dut_h2 (
        .clk(clk), .rst_n(rst_n[0]), .sample(sample[0]), .sample_valid(sample_valid[0]),
        .clr_overrun(clr_overrun[0]), .ready(ready[0]), .busy(busy[0]), .overrun(overrun[0]),
        .dac_cs_n(cs_n[0]), .dac_sclk(sclk[0]), .dac_sdi(sdi[0]), .dac_ldac_n(ldac_n[0])
    );

    dac_spi_driver #(.CLK_DIV(1)) u_dut_h1 (
        .clk(clk), .rst_n(rst_n[1]), .sample(sample[1]), .sample_valid(sample_valid[1]),
        .clr_overrun(clr_overrun[1]), .ready(ready[1]), .busy(busy[1]), .overrun(overrun[1]),
        .dac_cs_n(cs_n[1]), .dac_sclk(sclk[1]), .dac_sdi(sdi[1]), .dac_ldac_n(ldac_n[1])
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    int   n_vec = 0;
    int   n_cmp = 0;
    int   n_fail = 0;
    exp_t exp_q[$];
    exp_t e;

    // Reference model state (frame-level timeline per instance)
    int          free_edge   [NI];
    int          busy_last   [NI];
    logic        pend_full_m [NI];
    logic [11:0] pend_m      [NI];
    logic        ov_m        [NI];
    logic        nxt_ready   [NI] = '{1'b1, 1'b1};
    logic        nxt_busy    [NI] = '{1'b0, 1'b0};
    logic        nxt_ov      [NI] = '{1'b0, 1'b0};
    logic        exp_ready   [NI] = '{1'b1, 1'b1};
    logic        exp_busy    [NI] = '{1'b0, 1'b0};
    logic        exp_ov      [NI] = '{1'b0, 1'b0};

    // Monitor state
    logic        p_cs   [NI] = '{1'b1, 1'b1};
    logic        p_sclk [NI] = '{1'b0, 1'b0};
    logic        p_sdi  [NI] = '{1'b0, 1'b0};
    logic        p_ldac [NI] = '{1'b1, 1'b1};
    int          t_fall [NI];
    int          t_rise [NI];
    int          t_ldac [NI];
    int          run    [NI];
    int          bits   [NI];
    logic [15:0] shv    [NI];

    function automatic int h_of(input int i);
        return (i == 0) ? 2 : 1;
    endfunction

    function automatic void chk(input string nm, input int i, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s inst%0d cyc=%0d: got %0d, want %0d", nm, i, cyc, act, req);
        end
    endfunction

    function automatic void start_frame(input int i, input logic [11:0] s, input int x);
        exp_t n;
        n.inst  = i;
        n.frame = {4'h3, s};
        n.start = x;
        exp_q.push_back(n);
        free_edge[i] = x + 34 * h_of(i) + 1;
        busy_last[i] = x + 34 * h_of(i) - 1;
    endfunction

    // What the driver does at clock edge x, from the rules alone.
    function automatic void model_edge(input int i, input logic v, input logic [11:0] s,
                                       input logic c, input int x);
        logic drop;
        drop = 1'b0;
        if (x >= free_edge[i] && pend_full_m[i]) begin
            start_frame(i, pend_m[i], x);
            pend_full_m[i] = 1'b0;
            if (v) begin
                pend_m[i]      = s;
                pend_full_m[i] = 1'b1;
            end
        end else if (x >= free_edge[i] && v) begin
            start_frame(i, s, x);
        end else if (v) begin
            if (!pend_full_m[i]) begin
                pend_m[i]      = s;
                pend_full_m[i] = 1'b1;
            end else begin
                drop = 1'b1;
            end
        end
        if (drop) ov_m[i] = 1'b1;
        else if (c) ov_m[i] = 1'b0;
        nxt_ready[i] = !pend_full_m[i];
        nxt_busy[i]  = (x <= busy_last[i]);
        nxt_ov[i]    = ov_m[i];
    endfunction

    function automatic void model_reset(input int i);
        free_edge[i]   = 0;
        busy_last[i]   = -1;
        pend_full_m[i] = 1'b0;
        pend_m[i]      = '0;
        ov_m[i]        = 1'b0;
        nxt_ready[i]   = 1'b1;
        nxt_busy[i]    = 1'b0;
        nxt_ov[i]      = 1'b0;
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < NI; i++) begin
            exp_ready[i] <= nxt_ready[i];
            exp_busy[i]  <= nxt_busy[i];
            exp_ov[i]    <= nxt_ov[i];
        end
    end

    // Monitor: decode pins on the falling edge and compare with the scoreboard.
    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (!rst_n[i]) begin
                chk("rst_cs_n", i, cs_n[i], 1);
                chk("rst_sclk", i, sclk[i], 0);
                chk("rst_sdi", i, sdi[i], 0);
                chk("rst_ldac_n", i, ldac_n[i], 1);
                chk("rst_busy", i, busy[i], 0);
                chk("rst_ready", i, ready[i], 1);
                chk("rst_overrun", i, overrun[i], 0);
                run[i]  = 0;
                bits[i] = 0;
            end else begin
                chk("ready", i, ready[i], exp_ready[i]);
                chk("busy", i, busy[i], exp_busy[i]);
                chk("overrun", i, overrun[i], exp_ov[i]);
                if (sdi[i] != p_sdi[i]) chk("sdi_change_sclk", i, sclk[i], 0);
                if (!cs_n[i]) begin
                    if (p_cs[i]) begin
                        t_fall[i] = cyc;
                        bits[i]   = 0;
                        shv[i]    = '0;
                        run[i]    = 1;
                    end else if (sclk[i] != p_sclk[i]) begin
                        chk("sclk_half", i, run[i], h_of(i));
                        run[i] = 1;
                    end else begin
                        run[i]++;
                    end
                    if (sclk[i] && !p_sclk[i]) begin
                        shv[i] = {shv[i][14:0], sdi[i]};
                        bits[i]++;
                    end
                end else if (!p_cs[i]) begin
                    t_rise[i] = cyc;
                    chk("sclk_half_last", i, run[i], h_of(i));
                    chk("cs_low_len", i, cyc - t_fall[i], 32 * h_of(i));
                    chk("bit_count", i, bits[i], 16);
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL frame inst%0d cyc=%0d: got unexpected frame %h, want none",
                                 i, cyc, shv[i]);
                    end else begin
                        e = exp_q.pop_front();
                        chk("frame_inst", i, i, e.inst);
                        chk("frame", i, int'(shv[i]), int'(e.frame));
                        chk("frame_start", i, t_fall[i], e.start);
                    end
                end
                if (!ldac_n[i] && p_ldac[i]) begin
                    chk("ldac_delay", i, cyc - t_rise[i], h_of(i));
                    t_ldac[i] = cyc;
                end
                if (ldac_n[i] && !p_ldac[i]) chk("ldac_len", i, cyc - t_ldac[i], h_of(i));
            end
            p_cs[i]   = cs_n[i];
            p_sclk[i] = sclk[i];
            p_sdi[i]  = sdi[i];
            p_ldac[i] = ldac_n[i];
        end
    end

    task automatic tick(input int i, input logic v, input logic [11:0] s, input logic c);
        int x;
        x = cyc + 1;
        for (int j = 0; j < NI; j++) begin
            sample_valid[j] = (j == i) && v;
            sample[j]       = (j == i) ? s : 12'h000;
            clr_overrun[j]  = (j == i) && c;
            model_edge(j, sample_valid[j], sample[j], clr_overrun[j], x);
        end
        if (v) n_vec++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int i, input int n);
        repeat (n) tick(i, 1'b0, 12'h000, 1'b0);
    endtask

    // Asynchronous reset asserted mid-cycle, released away from the clock edge.
    task automatic do_reset(input int i);
        #2;
        rst_n[i] = 1'b0;
        model_reset(i);
        exp_q.delete();
        @(posedge clk);
        #1;
        idle(i, 2);
        rst_n[i] = 1'b1;
    endtask

    task automatic run_inst(input int i);
        int f;
        int d;
        f = 34 * h_of(i) + 1;
        tick(i, 1'b1, 12'hABC, 1'b0);
        idle(i, f + 4);
        tick(i, 1'b1, 12'h000, 1'b0);
        idle(i, f + 4);
        tick(i, 1'b1, 12'hFFF, 1'b0);
        idle(i, f + 4);
        // pending path
        tick(i, 1'b1, 12'h123, 1'b0);
        idle(i, 9);
        tick(i, 1'b1, 12'h456, 1'b0);
        idle(i, 2 * f + 4);
        // three samples in one frame, then clear
        for (int k = 0; k < 3; k++) begin
            tick(i, 1'b1, 12'($urandom), 1'b0);
            idle(i, 2);
        end
        idle(i, 2 * f);
        tick(i, 1'b0, 12'h000, 1'b1);
        idle(i, 2);
        // clear coincident with a drop: drop wins
        tick(i, 1'b1, 12'($urandom), 1'b0);
        tick(i, 1'b1, 12'($urandom), 1'b0);
        tick(i, 1'b1, 12'($urandom), 1'b1);
        idle(i, 2 * f + 4);
        tick(i, 1'b0, 12'h000, 1'b1);
        idle(i, 2);
        // reset during bit 7, then a clean frame
        tick(i, 1'b1, 12'h5A5, 1'b0);
        idle(i, 16 * h_of(i) + 1);
        do_reset(i);
        tick(i, 1'b1, 12'($urandom), 1'b0);
        idle(i, f + 4);
        // random strobes, including near-continuous bursts
        for (int k = 0; k < 500; k++) begin
            d = (k < 250) ? 30 : 3;
            tick(i, ($urandom_range(0, d) == 0), 12'($urandom), ($urandom_range(0, 15) == 0));
        end
        idle(i, 2 * f + 4);
    endtask

    initial begin
        for (int i = 0; i < NI; i++) begin
            rst_n[i]        = 1'b0;
            sample[i]       = 12'h000;
            sample_valid[i] = 1'b0;
            clr_overrun[i]  = 1'b0;
            t_fall[i]       = 0;
            t_rise[i]       = 0;
            t_ldac[i]       = 0;
            run[i]          = 0;
            bits[i]         = 0;
            shv[i]          = '0;
            model_reset(i);
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) rst_n[i] = 1'b1;
        run_inst(0);
        run_inst(1);
        chk("frames_outstanding", 0, exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
